// File: rtl/alu_iterative_if.sv
// Request/result bundle between the pipeline execute stage and the iterative ALU.
// The requester drives the operands and the controls; the ALU returns the result and its flags.
interface alu_iterative_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             done_o;
  logic             busy_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  data_o, zero_o, done_o, busy_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output data_o, zero_o, done_o, busy_o
  );
endinterface

// File: rtl/alu_iterative.sv
// Execution-stage ALU. ADD/SUB/AND/OR produce a result after one registered cycle.
// MUL uses a WIDTH-step shift-add loop and holds busy_o high so the hazard logic can stall.
module alu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_iterative_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             zero_q,  zero_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q,  mplr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_step;

  // State and datapath registers; reset takes effect immediately
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    cnt_d    = cnt_q;

    // Codes outside the single-cycle set (including unsupported ones) report zero
    case (bus.ALUCtrl_i)
      OP_ADD:  op_res = bus.data1_i + bus.data2_i;
      OP_SUB:  op_res = bus.data1_i - bus.data2_i;
      OP_AND:  op_res = bus.data1_i & bus.data2_i;
      OP_OR:   op_res = bus.data1_i | bus.data2_i;
      default: op_res = '0;
    endcase

    acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle drops the request
        if (!bus.flush_i && bus.start_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            acc_d   = '0;
            mcand_d = bus.data1_i;
            mplr_d  = bus.data2_i;
            cnt_d   = '0;
            state_d = ST_MUL;
          end else begin
            data_d = op_res;
            zero_d = (op_res == '0);
            done_d = 1'b1;
          end
        end
      end

      ST_MUL: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          // The last step retires the product, including this step's add
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            data_d  = acc_step;
            zero_d  = (acc_step == '0);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.data_o = data_q;
  assign bus.zero_o = zero_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: single-cycle ops, MUL latency, flush, reset abort, illegal codes.
module tb_alu_iterative;
  localparam int unsigned WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_iterative_if #(.WIDTH(WIDTH)) bus ();

  alu_iterative #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [34:0] obs;
  logic [34:0] exp_v;

  task automatic drive(input logic s, input logic [2:0] c,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start_i   = s;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask

  // Advance one negedge at a time until done_o is seen or the budget runs out
  task automatic wait_done(input int budget, output int busy_cnt, output bit seen);
    int n;
    busy_cnt = 0;
    seen     = 1'b0;
    n        = 0;
    while (!seen && n < budget) begin
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        if (bus.busy_o) busy_cnt++;
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bus.flush_i = 1'b0;
    drive(1'b0, 3'b000, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'h0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v); end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_add_sub();
    drive(1'b1, 3'b000, 32'd5, 32'd7);
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'd12, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL add_5_7 got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 3'b001, 32'd3, 32'd5);
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sub_3_5 got=%h exp=%h", obs, exp_v); end
    drive(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL idle_hold got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_logic();
    drive(1'b1, 3'b001, 32'h1234, 32'h1234);
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'h0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL sub_equal got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 3'b010, 32'hF0F0, 32'h0F0F);
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL and_disjoint got=%h exp=%h", obs, exp_v); end
    drive(1'b1, 3'b011, 32'hF000, 32'h000F);
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'h0000_F00F, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL or_merge got=%h exp=%h", obs, exp_v); end
    drive(1'b0, 3'b000, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_mul();
    int  bc;
    bit  seen;
    drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd3);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'h0000_F00F, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mul_start_busy got=%h exp=%h", obs, exp_v); end
    wait_done(40, bc, seen);
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL mul_done_seen got=%0d exp=1", seen); end
    checks++;
    if (bc !== 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", bc); end
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mul_result got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mul_done_single got=%h exp=%h", obs, exp_v); end

    drive(1'b1, 3'b101, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    wait_done(40, bc, seen);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'h0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mul_overflow_zero got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [WIDTH-1:0] last;
    dones = 0;
    last  = '0;
    drive(1'b1, 3'b101, 32'd6, 32'd7);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    repeat (4) @(negedge clk);
    drive(1'b1, 3'b000, 32'd1, 32'd1);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) begin dones++; last = bus.data_o; end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL mid_mul_done_count got=%0d exp=1", dones); end
    checks++;
    if (last !== 32'd42) begin failures++; $display("FAIL mid_mul_result got=%h exp=%h", last, 32'd42); end
  endtask

  task automatic test_flush();
    int dones;
    dones = 0;
    drive(1'b1, 3'b101, 32'd9, 32'd9);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'd42, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL flush_abort got=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    drive(1'b1, 3'b000, 32'd2, 32'd2);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL flush_idle_drop got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'd4, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL add_after_flush got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int bc;
    bit seen;
    drive(1'b1, 3'b101, 32'd5, 32'd5);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'h0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rst_mid_mul got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'b101, 32'd7, 32'd8);
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0);
    wait_done(40, bc, seen);
    checks++;
    if (bc !== 32) begin failures++; $display("FAIL post_rst_busy_cycles got=%0d exp=32", bc); end
    obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
    exp_v = {32'd56, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL post_rst_mul got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [2:0] codes [3];
    codes[0] = 3'b110;
    codes[1] = 3'b100;
    codes[2] = 3'b111;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 32'd1, 32'd2);
      @(negedge clk);
      drive(1'b1, codes[k], 32'd9, 32'd9);
      @(negedge clk);
      drive(1'b0, 3'b000, '0, '0);
      obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
      exp_v = {32'h0, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL illegal_code_%0d got=%h exp=%h", k, obs, exp_v); end
      @(negedge clk);
      obs = {bus.data_o, bus.zero_o, bus.done_o, bus.busy_o};
      exp_v = {32'h0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL illegal_single_done_%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_mul();
    test_start_ignored();
    test_flush();
    test_reset_mid_mul();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
